// File: rtl/wisc_mem_pkg.sv
// Shared types and default widths for the single-port memory arbiter.
// Holds the arbiter state encoding and the default address/data widths.
package wisc_mem_pkg;

    localparam int DEF_ADDR_W = 16;
    localparam int DEF_DATA_W = 16;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY_IF = 2'd1,
        BUSY_DM = 2'd2
    } arb_state_t;

endpackage

// File: rtl/mem_lat_counter.sv
// Memory-access latency down-counter: loads on grant, counts down per busy cycle.
// Ports: clk, rst, load, dec, load_val[W], zero (count == 0). Never wraps below 0.
module mem_lat_counter #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         dec,
    input  logic [W-1:0] load_val,
    output logic         zero
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && cnt != '0) begin
            cnt <= cnt - W'(1);
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates one memory port between instruction fetch and data memory.
// Ports: fetch (if_*), data (dm_*), memory (mem_*), and combinational stall.
module mem_arbiter
    import wisc_mem_pkg::*;
#(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int MEM_LAT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ready,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              dm_ready,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              stall
);

    localparam int CW = $clog2(MEM_LAT + 1);
    localparam logic [CW-1:0] LOAD_VAL = CW'(MEM_LAT - 1);

    arb_state_t state, nxt;

    logic              grant_if, grant_dm, done, cnt_dec, cnt_zero;
    logic [ADDR_W-1:0] cap_addr;
    logic [DATA_W-1:0] cap_wdata;
    logic              cap_we;

    mem_lat_counter #(.W(CW)) u_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (grant_if | grant_dm),
        .dec      (cnt_dec),
        .load_val (LOAD_VAL),
        .zero     (cnt_zero)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= nxt;
    end

    // A requester whose ready is high is still holding the request it
    // just completed, so it is masked to avoid a duplicate grant.
    always_comb begin
        nxt      = state;
        grant_if = 1'b0;
        grant_dm = 1'b0;
        done     = 1'b0;
        cnt_dec  = 1'b0;
        unique case (state)
            IDLE: begin
                if (dm_req && !dm_ready) begin
                    nxt      = BUSY_DM;
                    grant_dm = 1'b1;
                end else if (if_req && !if_ready) begin
                    nxt      = BUSY_IF;
                    grant_if = 1'b1;
                end
            end
            BUSY_IF, BUSY_DM: begin
                if (cnt_zero) begin
                    nxt  = IDLE;
                    done = 1'b1;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cap_addr  <= '0;
            cap_wdata <= '0;
            cap_we    <= 1'b0;
            if_ready  <= 1'b0;
            dm_ready  <= 1'b0;
            if_rdata  <= '0;
            dm_rdata  <= '0;
        end else begin
            if_ready <= 1'b0;
            dm_ready <= 1'b0;
            if (grant_dm) begin
                cap_addr  <= dm_addr;
                cap_wdata <= dm_wdata;
                cap_we    <= dm_we;
            end else if (grant_if) begin
                cap_addr  <= if_addr;
                cap_wdata <= '0;
                cap_we    <= 1'b0;
            end
            if (done) begin
                if (state == BUSY_IF) begin
                    if_ready <= 1'b1;
                    if_rdata <= mem_rdata;
                end else begin
                    dm_ready <= 1'b1;
                    if (!cap_we) dm_rdata <= mem_rdata;
                end
            end
        end
    end

    assign mem_en    = (state != IDLE);
    assign mem_we    = (state == BUSY_DM) & cap_we;
    assign mem_addr  = cap_addr;
    assign mem_wdata = cap_wdata;

    assign stall = (if_req & ~if_ready) | (dm_req & ~dm_ready);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter with MEM_LAT = 4.
// Cycle k is the interval just after the k-th rising edge of a scenario.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [15:0] if_addr;
    logic [15:0] if_rdata;
    logic        if_ready;
    logic        dm_req;
    logic        dm_we;
    logic [15:0] dm_addr;
    logic [15:0] dm_wdata;
    logic [15:0] dm_rdata;
    logic        dm_ready;
    logic        mem_en;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        stall;

    int n_tests = 0;
    int n_fail  = 0;

    mem_arbiter #(.ADDR_W(16), .DATA_W(16), .MEM_LAT(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_rdata  (if_rdata),
        .if_ready  (if_ready),
        .dm_req    (dm_req),
        .dm_we     (dm_we),
        .dm_addr   (dm_addr),
        .dm_wdata  (dm_wdata),
        .dm_rdata  (dm_rdata),
        .dm_ready  (dm_ready),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .stall     (stall)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst       = 1'b1;
        if_req    = 1'b0;
        if_addr   = '0;
        dm_req    = 1'b0;
        dm_we     = 1'b0;
        dm_addr   = '0;
        dm_wdata  = '0;
        mem_rdata = '0;
        step();
        step();
        check("rst_mem_en", mem_en, 0);
        check("rst_mem_we", mem_we, 0);
        check("rst_if_ready", if_ready, 0);
        check("rst_dm_ready", dm_ready, 0);
        check("rst_if_rdata", if_rdata, 0);
        check("rst_dm_rdata", dm_rdata, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_stall", stall, 0);
        rst = 1'b0;
        step();

        // single read
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 16'h0040;
        mem_rdata = 16'hBEEF;
        #1;
        check("rd_c0_stall", stall, 1);
        check("rd_c0_mem_en", mem_en, 0);
        for (int c = 1; c <= 4; c++) begin
            step();
            check($sformatf("rd_c%0d_mem_en", c), mem_en, 1);
            check($sformatf("rd_c%0d_mem_addr", c), mem_addr, 32'h0040);
            check($sformatf("rd_c%0d_mem_we", c), mem_we, 0);
            check($sformatf("rd_c%0d_dm_ready", c), dm_ready, 0);
            check($sformatf("rd_c%0d_stall", c), stall, 1);
        end
        step();
        check("rd_c5_dm_ready", dm_ready, 1);
        check("rd_c5_dm_rdata", dm_rdata, 32'hBEEF);
        check("rd_c5_mem_en", mem_en, 0);
        check("rd_c5_stall", stall, 0);
        dm_req = 1'b0;
        step();
        check("rd_c6_dm_ready", dm_ready, 0);
        check("rd_c6_mem_en", mem_en, 0);

        // write
        dm_req = 1'b1; dm_we = 1'b1; dm_addr = 16'h0010;
        dm_wdata = 16'h1234; mem_rdata = 16'hDEAD;
        for (int c = 1; c <= 4; c++) begin
            step();
            check($sformatf("wr_c%0d_mem_we", c), mem_we, 1);
            check($sformatf("wr_c%0d_mem_addr", c), mem_addr, 32'h0010);
            check($sformatf("wr_c%0d_mem_wdata", c), mem_wdata, 32'h1234);
        end
        step();
        check("wr_c5_dm_ready", dm_ready, 1);
        check("wr_c5_dm_rdata", dm_rdata, 32'hBEEF);
        check("wr_c5_mem_we", mem_we, 0);
        dm_req = 1'b0; dm_we = 1'b0;
        step();

        // simultaneous, both held: DM, IF, DM
        if_req = 1'b1; if_addr = 16'h0100;
        dm_req = 1'b1; dm_addr = 16'h0200; mem_rdata = 16'h1111;
        for (int c = 1; c <= 4; c++) begin
            step();
            check($sformatf("sim_c%0d_mem_addr", c), mem_addr, 32'h0200);
            check($sformatf("sim_c%0d_mem_en", c), mem_en, 1);
        end
        step();
        check("sim_c5_dm_ready", dm_ready, 1);
        check("sim_c5_dm_rdata", dm_rdata, 32'h1111);
        check("sim_c5_if_ready", if_ready, 0);
        check("sim_c5_stall", stall, 1);
        mem_rdata = 16'h2222;
        for (int c = 6; c <= 9; c++) begin
            step();
            check($sformatf("sim_c%0d_mem_addr", c), mem_addr, 32'h0100);
            check($sformatf("sim_c%0d_mem_en", c), mem_en, 1);
            check($sformatf("sim_c%0d_mem_we", c), mem_we, 0);
            check($sformatf("sim_c%0d_dm_ready", c), dm_ready, 0);
        end
        step();
        check("sim_c10_if_ready", if_ready, 1);
        check("sim_c10_if_rdata", if_rdata, 32'h2222);
        check("sim_c10_mem_en", mem_en, 0);
        if_req = 1'b0; mem_rdata = 16'h3333;
        for (int c = 11; c <= 14; c++) begin
            step();
            check($sformatf("sim_c%0d_mem_addr", c), mem_addr, 32'h0200);
            check($sformatf("sim_c%0d_if_ready", c), if_ready, 0);
        end
        step();
        check("sim_c15_dm_ready", dm_ready, 1);
        check("sim_c15_dm_rdata", dm_rdata, 32'h3333);
        dm_req = 1'b0;
        step();
        check("sim_c16_mem_en", mem_en, 0);
        check("sim_c16_dm_ready", dm_ready, 0);

        // reset in cycle 2 of a fetch
        if_req = 1'b1; if_addr = 16'h0300; mem_rdata = 16'h4444;
        step();
        check("rf_c1_mem_en", mem_en, 1);
        step();
        check("rf_c2_mem_en", mem_en, 1);
        rst = 1'b1;
        step();
        check("rf_c3_mem_en", mem_en, 0);
        check("rf_c3_if_ready", if_ready, 0);
        check("rf_c3_if_rdata", if_rdata, 0);
        check("rf_c3_dm_rdata", dm_rdata, 0);
        rst = 1'b0;
        for (int c = 4; c <= 7; c++) begin
            step();
            check($sformatf("rf_c%0d_mem_en", c), mem_en, 1);
            check($sformatf("rf_c%0d_mem_addr", c), mem_addr, 32'h0300);
            check($sformatf("rf_c%0d_if_ready", c), if_ready, 0);
        end
        step();
        check("rf_c8_if_ready", if_ready, 1);
        check("rf_c8_if_rdata", if_rdata, 32'h4444);
        check("rf_c8_stall", stall, 0);
        if_req = 1'b0;
        step();
        check("rf_c9_if_ready", if_ready, 0);
        check("rf_c9_mem_en", mem_en, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
